// File: rtl/uart_param_tx_if.sv
// Word handshake between an upstream producer and the UART transmitter.
//   data_valid : producer has a word on data
//   data_ready : transmitter accepts the word on this clock edge
//   data       : payload, sampled only on the accepting edge
interface uart_param_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;

  // Producer side
  modport master (
    output data_valid,
    output data,
    input  data_ready
  );

  // Transmitter side
  modport slave (
    input  data_valid,
    input  data,
    output data_ready
  );
endinterface

// File: rtl/uart_param_tx.sv
// Parametrised UART transmitter. One DATA_WIDTH-bit word per frame, LSB
// first, optional parity bit after the MSB, then 1 or 2 stop bits. Each
// serial bit lasts OVERSAMPLE pulses of i_baud_tick.
//   i_clk       : system clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_baud_tick : one-clock oversample strobe from the shared baud generator
//   bus         : valid/ready word input (data_valid, data_ready, data)
//   o_tx        : serial line, idle high (registered)
//   o_busy      : high from accept until the frame ends (registered)
//   o_done      : one-clock pulse when the last stop bit completes (registered)
module uart_param_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_baud_tick,
  uart_param_tx_if.slave bus,
  output logic           o_tx,
  output logic           o_busy,
  output logic           o_done
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  // Bit index also counts stop bits, so it needs at least one bit.
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_tick_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_parity_nxt;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_accept;
  logic                  w_bit_end;

  // Ready only in IDLE and never while reset is held.
  assign bus.data_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept       = bus.data_valid && bus.data_ready;

  // Current serial bit finishes on the tick that wraps the oversample counter.
  assign w_bit_end = i_baud_tick && (r_tick_cnt == CNT_W'(OVERSAMPLE - 1));

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_cnt_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_tick_cnt;
    w_idx_nxt    = r_bit_idx;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    // Oversample counter only moves on baud ticks while a frame is active;
    // a tick on the accepting edge is therefore not counted.
    if ((r_state != S_IDLE) && i_baud_tick) begin
      w_cnt_nxt = w_bit_end ? '0 : r_tick_cnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        if (w_accept) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = bus.data;
          w_parity_nxt = (^bus.data) ^ 1'(PARITY_ODD);
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = '0;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_idx_nxt = '0;
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_idx_nxt   = r_bit_idx + IDX_W'(1);
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
          w_idx_nxt   = '0;
        end
      end

      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_bit_idx == IDX_W'(STOP_BITS - 1)) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_uart_param_tx.sv
// Self-checking bench for uart_param_tx. Five configurations share one
// clock, reset and baud strobe; sel routes data_valid to one instance and
// picks which instance's outputs are observed. Expected tx waveforms are
// pushed to a queue when a word is driven and popped when compared.
module tb_uart_param_tx;

  logic        clk = 1'b0;
  logic        s_rst;
  logic        s_tick;
  logic        s_valid;
  logic [31:0] s_data;
  int          sel;
  int          n_tests;
  int          n_fail;

  logic [255:0] exp_q[$];

  logic [255:0] cap_tx_v;
  logic [255:0] cap_busy_v;
  logic [255:0] cap_done_v;
  logic [255:0] cap_ready_v;

  wire [4:0] tx_w;
  wire [4:0] busy_w;
  wire [4:0] done_w;
  wire [4:0] ready_w;

  always #5 clk = ~clk;

  uart_param_tx_if #(.DATA_WIDTH(8))  a_if ();
  uart_param_tx_if #(.DATA_WIDTH(8))  b_if ();
  uart_param_tx_if #(.DATA_WIDTH(8))  c_if ();
  uart_param_tx_if #(.DATA_WIDTH(32)) d_if ();
  uart_param_tx_if #(.DATA_WIDTH(8))  e_if ();

  assign a_if.data_valid = s_valid && (sel == 0);
  assign b_if.data_valid = s_valid && (sel == 1);
  assign c_if.data_valid = s_valid && (sel == 2);
  assign d_if.data_valid = s_valid && (sel == 3);
  assign e_if.data_valid = s_valid && (sel == 4);
  assign a_if.data = s_data[7:0];
  assign b_if.data = s_data[7:0];
  assign c_if.data = s_data[7:0];
  assign d_if.data = s_data;
  assign e_if.data = s_data[7:0];
  assign ready_w = {e_if.data_ready, d_if.data_ready, c_if.data_ready,
                    b_if.data_ready, a_if.data_ready};

  uart_param_tx #(.DATA_WIDTH(8), .OVERSAMPLE(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst(s_rst), .i_baud_tick(s_tick), .bus(a_if),
    .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));
  uart_param_tx #(.DATA_WIDTH(8), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .i_clk(clk), .i_rst(s_rst), .i_baud_tick(s_tick), .bus(b_if),
    .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));
  uart_param_tx #(.DATA_WIDTH(8), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .i_clk(clk), .i_rst(s_rst), .i_baud_tick(s_tick), .bus(c_if),
    .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));
  uart_param_tx u_d (
    .i_clk(clk), .i_rst(s_rst), .i_baud_tick(s_tick), .bus(d_if),
    .o_tx(tx_w[3]), .o_busy(busy_w[3]), .o_done(done_w[3]));
  uart_param_tx #(.DATA_WIDTH(8), .OVERSAMPLE(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_e (
    .i_clk(clk), .i_rst(s_rst), .i_baud_tick(s_tick), .bus(e_if),
    .o_tx(tx_w[4]), .o_busy(busy_w[4]), .o_done(done_w[4]));

  // Serial bit list: start, data LSB first, optional parity, stops, idle ones after.
  function automatic logic [63:0] exp_bits(input logic [31:0] w, input int dw,
                                            input int par_en, input int par_odd);
    logic [63:0] b;
    logic        p;
    b    = '1;
    b[0] = 1'b0;
    p    = par_odd[0];
    for (int i = 0; i < dw; i++) begin
      b[1+i] = w[i];
      p      = p ^ w[i];
    end
    if (par_en != 0) b[1+dw] = p;
    return b;
  endfunction

  // Per-clock tx waveform with 4 clocks per bit (baud_tick tied high).
  function automatic logic [255:0] exp_frame(input logic [31:0] w, input int dw,
                                             input int par_en, input int par_odd);
    logic [63:0]  b;
    logic [255:0] s;
    b = exp_bits(w, dw, par_en, par_odd);
    for (int c = 0; c < 256; c++) s[c] = b[c/4];
    return s;
  endfunction

  // Offer a word to the selected instance; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] w, input bit keep);
    int waited;
    waited = 0;
    @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    while (ready_w[sel] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (ready_w[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: inst %0d ready=%b after %0d clks, required 1", sel, ready_w[sel], waited);
    end
    @(posedge clk);
    #1;
    if (!keep) s_valid = 1'b0;
  endtask

  // Record selected outputs for n clocks; sample c is #1 after edge c past accept.
  task automatic capture(input int n, input int v_off, input int v_on,
                         input logic [31:0] on_data, input int rst_at);
    cap_tx_v    = '1;
    cap_busy_v  = '0;
    cap_done_v  = '0;
    cap_ready_v = '0;
    for (int c = 0; c < n; c++) begin
      cap_tx_v[c]    = tx_w[sel];
      cap_busy_v[c]  = busy_w[sel];
      cap_done_v[c]  = done_w[sel];
      cap_ready_v[c] = ready_w[sel];
      @(negedge clk);
      if (c == v_off) s_valid = 1'b0;
      if (c == v_on) begin
        s_valid = 1'b1;
        s_data  = on_data;
      end
      s_rst = (c == rst_at);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    s_rst = 1'b1; s_tick = 1'b1; s_valid = 1'b0; s_data = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (tx_w !== 5'b11111) begin n_fail++; $display("FAIL reset_tx: got %b required 11111", tx_w); end
    n_tests++;
    if (busy_w !== 5'b00000 || done_w !== 5'b00000) begin
      n_fail++; $display("FAIL reset_busy_done: busy=%b done=%b required 00000", busy_w, done_w);
    end
    n_tests++;
    if (ready_w !== 5'b00000) begin n_fail++; $display("FAIL reset_ready: got %b required 00000", ready_w); end
    @(negedge clk);
    s_rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (ready_w !== 5'b11111 || tx_w !== 5'b11111) begin
      n_fail++; $display("FAIL post_reset: ready=%b tx=%b required 11111/11111", ready_w, tx_w);
    end
  endtask

  task automatic test_basic;
    logic [255:0] e;
    sel = 0;
    exp_q.push_back(exp_frame(32'hA5, 8, 0, 0));
    send(32'hA5, 1'b0);
    capture(50, -1, -1, 32'h0, -1);
    e = exp_q.pop_front();
    n_tests++;
    if (cap_tx_v[49:0] !== e[49:0]) begin
      n_fail++; $display("FAIL basic_frame: got %h required %h", cap_tx_v[49:0], e[49:0]);
    end
    n_tests++;
    if (cap_done_v[40] !== 1'b1 || $countones(cap_done_v[49:0]) != 1) begin
      n_fail++; $display("FAIL basic_done: got %h required done only at clk 40", cap_done_v[49:0]);
    end
    n_tests++;
    if (cap_busy_v[49:0] !== {10'b0, {40{1'b1}}}) begin
      n_fail++; $display("FAIL basic_busy: got %h required busy clks 0..39", cap_busy_v[49:0]);
    end
  endtask

  task automatic test_parity;
    logic [255:0] e;
    for (int k = 0; k < 2; k++) begin
      sel = 1 + k;
      exp_q.push_back(exp_frame((k == 0) ? 32'h07 : 32'h03, 8, 1, k));
      send((k == 0) ? 32'h07 : 32'h03, 1'b0);
      capture(50, -1, -1, 32'h0, -1);
      e = exp_q.pop_front();
      n_tests++;
      if (cap_tx_v[49:0] !== e[49:0]) begin
        n_fail++; $display("FAIL parity_frame%0d: got %h required %h", k, cap_tx_v[49:0], e[49:0]);
      end
      n_tests++;
      if (cap_tx_v[39:36] !== 4'b1111) begin
        n_fail++; $display("FAIL parity_bit%0d: got %b required 1111", k, cap_tx_v[39:36]);
      end
      n_tests++;
      if (cap_done_v[44] !== 1'b1 || $countones(cap_done_v[49:0]) != 1) begin
        n_fail++; $display("FAIL parity_done%0d: got %h required done only at clk 44", k, cap_done_v[49:0]);
      end
    end
  endtask

  task automatic test_defaults;
    logic [255:0] e;
    logic [33:0]  dec;
    logic         prev;
    int           ticks, done_clk, done_ticks, extra_done, jitter;
    sel = 3;
    e = '0;
    e[63:0] = exp_bits(32'hDEADBEEF, 32, 0, 0);
    exp_q.push_back(e);
    // Accept lands on a tick edge; that tick must not count.
    @(negedge clk);
    s_data = 32'hDEADBEEF; s_valid = 1'b1; s_tick = 1'b1;
    n_tests++;
    if (ready_w[3] !== 1'b1) begin n_fail++; $display("FAIL dflt_ready: got %b required 1", ready_w[3]); end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    ticks = 0; done_clk = -1; done_ticks = -1; extra_done = 0; jitter = 0;
    dec = '1;
    prev = tx_w[3];
    for (int c = 1; c <= 2300; c++) begin
      @(negedge clk);
      s_tick = (c % 4 == 0);
      @(posedge clk);
      #1;
      if (s_tick) ticks++;
      else if (tx_w[3] !== prev) jitter++;
      prev = tx_w[3];
      if (s_tick && (ticks % 16 == 8) && (ticks / 16 < 34)) dec[ticks/16] = tx_w[3];
      if (done_w[3] === 1'b1) begin
        if (done_clk < 0) begin done_clk = c; done_ticks = ticks; end
        else extra_done++;
      end
    end
    s_tick = 1'b1;
    e = exp_q.pop_front();
    n_tests++;
    if (dec !== e[33:0]) begin n_fail++; $display("FAIL dflt_bits: got %h required %h", dec, e[33:0]); end
    n_tests++;
    if (done_clk != 2176 || done_ticks != 544 || extra_done != 0) begin
      n_fail++; $display("FAIL dflt_done: clk %0d ticks %0d extra %0d, required 2176/544/0", done_clk, done_ticks, extra_done);
    end
    n_tests++;
    if (jitter != 0) begin n_fail++; $display("FAIL dflt_stable: got %0d changes between ticks, required 0", jitter); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] f1, f2;
    sel = 4;
    exp_q.push_back(exp_frame(32'h11, 8, 0, 0));
    exp_q.push_back(exp_frame(32'h22, 8, 0, 0));
    send(32'h11, 1'b1);
    s_data = 32'h22;
    capture(95, 45, -1, 32'h0, -1);
    f1 = exp_q.pop_front();
    f2 = exp_q.pop_front();
    n_tests++;
    if (cap_tx_v[43:0] !== f1[43:0]) begin
      n_fail++; $display("FAIL b2b_frame1: got %h required %h", cap_tx_v[43:0], f1[43:0]);
    end
    n_tests++;
    if (cap_tx_v[44] !== 1'b1 || cap_ready_v[44] !== 1'b1 || cap_ready_v[43:0] !== 44'h0) begin
      n_fail++; $display("FAIL b2b_gap: tx44=%b ready=%h required 1 / ready only at clk 44", cap_tx_v[44], cap_ready_v[44:0]);
    end
    n_tests++;
    if (cap_tx_v[94:45] !== f2[49:0]) begin
      n_fail++; $display("FAIL b2b_frame2: got %h required %h", cap_tx_v[94:45], f2[49:0]);
    end
    n_tests++;
    if (cap_done_v[44] !== 1'b1 || cap_done_v[89] !== 1'b1 || $countones(cap_done_v[94:0]) != 2) begin
      n_fail++; $display("FAIL b2b_done: got %h required done at clks 44 and 89", cap_done_v[94:0]);
    end
  endtask

  task automatic test_busy_ignore;
    logic [255:0] e;
    sel = 0;
    exp_q.push_back(exp_frame(32'h0F, 8, 0, 0));
    send(32'h0F, 1'b0);
    capture(100, 30, 5, 32'h55, -1);
    e = exp_q.pop_front();
    n_tests++;
    if (cap_tx_v[99:0] !== e[99:0]) begin
      n_fail++; $display("FAIL ignore_frame: got %h required %h", cap_tx_v[99:0], e[99:0]);
    end
    n_tests++;
    if (cap_ready_v[39:0] !== 40'h0 || cap_ready_v[40] !== 1'b1) begin
      n_fail++; $display("FAIL ignore_ready: got %h required low until clk 40", cap_ready_v[40:0]);
    end
    n_tests++;
    if (cap_busy_v[99:40] !== 60'h0 || $countones(cap_done_v[99:0]) != 1) begin
      n_fail++; $display("FAIL ignore_extra: busy=%h done=%h required no second frame", cap_busy_v[99:40], cap_done_v[99:0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] e;
    sel = 0;
    exp_q.push_back(exp_frame(32'hFF, 8, 0, 0));
    send(32'hFF, 1'b0);
    capture(60, -1, -1, 32'h0, 12);
    e = exp_q.pop_front();
    n_tests++;
    if (cap_tx_v[12:0] !== e[12:0]) begin
      n_fail++; $display("FAIL rstmid_prefix: got %h required %h", cap_tx_v[12:0], e[12:0]);
    end
    n_tests++;
    if (cap_tx_v[13] !== 1'b1 || cap_busy_v[13] !== 1'b0 || cap_ready_v[13] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state: tx=%b busy=%b ready=%b required 1/0/0",
                         cap_tx_v[13], cap_busy_v[13], cap_ready_v[13]);
    end
    n_tests++;
    if (cap_ready_v[14] !== 1'b1 || cap_tx_v[59:13] !== {47{1'b1}} || cap_done_v[59:0] !== 60'h0) begin
      n_fail++; $display("FAIL rstmid_after: ready14=%b tx=%h done=%h required 1 / idle / no done",
                         cap_ready_v[14], cap_tx_v[59:13], cap_done_v[59:0]);
    end
    exp_q.push_back(exp_frame(32'h00, 8, 0, 0));
    send(32'h00, 1'b0);
    capture(45, -1, -1, 32'h0, -1);
    e = exp_q.pop_front();
    n_tests++;
    if (cap_tx_v[44:0] !== e[44:0] || cap_done_v[40] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_next: got %h done40=%b required %h / 1", cap_tx_v[44:0], cap_done_v[40], e[44:0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_parity();
    test_defaults();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
